// File: rtl/cas_tape_capture.sv
// Sord M5 cassette save-stream capture: decodes tape-out cycle lengths into
// framed bytes and queues them in a small FIFO for HPS upload.
module cas_tape_capture #(
    parameter logic [15:0] SHORT_MAX  = 16'd3000,
    parameter logic [15:0] LONG_MAX   = 16'd6000,
    parameter logic [15:0] IDLE_TICKS = 16'd20000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clk_en_i,
    input  logic                  cas_i,
    input  logic                  ioctl_upload_i,
    input  logic                  ioctl_rd_i,
    output logic [7:0]            ioctl_din_o,
    output logic                  rec_active_o,
    output logic [DEPTH_LOG2:0]   fifo_level_o,
    output logic [15:0]           byte_count_o,
    output logic                  frame_err_o,
    output logic                  overflow_o,
    output logic                  underrun_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic                  cas_prev_r;
    logic [15:0]           period_r;
    logic [1:0]            state_r;
    logic [2:0]            bit_idx_r;
    logic [7:0]            shift_r;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_r;
    logic [DEPTH_LOG2:0]   rd_ptr_r;

    logic rise_s;
    logic is_one_s;
    logic is_zero_s;
    logic timeout_s;
    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;
    logic accept_s;

    // Edge, classification and FIFO handshake decode.
    always_comb begin
        rise_s    = clk_en_i & ~cas_prev_r & cas_i;
        is_one_s  = (period_r < SHORT_MAX);
        is_zero_s = ~is_one_s & (period_r < LONG_MAX);
        timeout_s = (state_r != ST_IDLE) && (period_r >= IDLE_TICKS);
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                    (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
        if (!timeout_s && rise_s && state_r == ST_STOP && is_one_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s    = ioctl_rd_i & ioctl_upload_i & ~empty_s;
        // A pop in the same cycle frees the slot a full FIFO needs.
        accept_s = push_s & (~full_s | pop_s);
    end

    // Tape level history and saturating period counter in enabled ticks.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cas_prev_r <= 1'b0;
            period_r   <= 16'd0;
        end else if (clk_en_i) begin
            cas_prev_r <= cas_i;
            if (rise_s) begin
                period_r <= 16'd1;
            end else if (period_r != 16'hFFFF) begin
                period_r <= period_r + 16'd1;
            end
        end
    end

    // Frame FSM: leader hunt, start bit, eight LSB-first data bits, stop bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            rec_active_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else if (timeout_s) begin
            state_r      <= ST_IDLE;
            rec_active_o <= 1'b0;
            bit_idx_r    <= 3'd0;
        end else if (rise_s) begin
            case (state_r)
                ST_IDLE: begin
                    state_r      <= ST_HUNT;
                    rec_active_o <= 1'b1;
                end
                ST_HUNT: begin
                    if (is_zero_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (!is_one_s && !is_zero_s) begin
                        state_r <= ST_HUNT;
                    end else begin
                        shift_r <= {is_one_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (!is_one_s) begin
                        frame_err_o <= 1'b1;
                    end
                    state_r <= ST_HUNT;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= shift_r;
        end
    end

    // FIFO pointers, level, counters, upload read port and sticky flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_level_o <= '0;
            byte_count_o <= 16'd0;
            ioctl_din_o  <= 8'h00;
            overflow_o   <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (byte_count_o != 16'hFFFF) begin
                    byte_count_o <= byte_count_o + 16'd1;
                end
            end
            if (push_s && !accept_s) begin
                overflow_o <= 1'b1;
            end
            if (ioctl_rd_i && ioctl_upload_i) begin
                if (empty_s) begin
                    ioctl_din_o <= 8'h00;
                    underrun_o  <= 1'b1;
                end else begin
                    ioctl_din_o <= mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
                    rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                end
            end
            case ({accept_s, pop_s})
                2'b10:   fifo_level_o <= fifo_level_o + PTR_ONE;
                2'b01:   fifo_level_o <= fifo_level_o - PTR_ONE;
                default: fifo_level_o <= fifo_level_o;
            endcase
        end
    end

endmodule
